// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
//
// Contents:
//   MIN_DIV    - smallest divisor a channel is allowed to run with
//   ch_state_e - per-channel run state (IDLE / RUN)
//   ch_width() - width of the channel-select field, never below one bit
package clkdiv_pkg;

    localparam int MIN_DIV = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    // $clog2(1) is 0, so a single-channel build still gets a 1-bit select
    function automatic int ch_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One channel of the multi-channel clock divider.
//
// Divides inclk by a runtime-programmable divisor D. The output is high for
// D - (D>>1) cycles and low for D>>1 cycles, so odd divisors put the extra
// cycle in the high phase. Divisor changes and stop requests only take
// effect at the end of a full period, so no runt pulse is ever produced.
//
// Ports:
//   inclk   - system clock
//   reset   - asynchronous active-low reset
//   wr      - decoded write strobe for this channel
//   wr_div  - divisor value carried by the write
//   en      - run request, level-sensitive
//   outclk  - divided clock (registered)
//   tick    - one-cycle pulse with each outclk rising edge
//   active  - channel is running
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RESET_DIV = 2
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             en,
    output logic             outclk,
    output logic             tick,
    output logic             active
);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             outclk_q, outclk_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] next_div;
    logic             wrap;
    logic             start_ok;
    logic             next_ok;

    // State register: every piece of channel state, cleared asynchronously
    always_ff @(posedge inclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= WIDTH'(RESET_DIV);
            pdiv_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            outclk_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            pdiv_q   <= pdiv_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            outclk_q <= outclk_d;
            tick_q   <= tick_d;
        end
    end

    // Next-state logic. The divisor used for the following period is picked
    // at the wrap edge: a write landing on that same edge wins over a pending
    // value, which in turn wins over the current divisor.
    always_comb begin
        high_len = div_q - (div_q >> 1);
        cnt_inc  = cnt_q + WIDTH'(1);
        wrap     = (state_q == RUN) && (cnt_q == div_q - WIDTH'(1));
        next_div = wr ? wr_div : (pend_q ? pdiv_q : div_q);
        next_ok  = (next_div >= WIDTH'(MIN_DIV));
        start_ok = en && (div_q >= WIDTH'(MIN_DIV));

        state_d  = state_q;
        div_d    = div_q;
        pdiv_d   = pdiv_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        outclk_d = outclk_q;
        tick_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                pend_d   = 1'b0;
                outclk_d = 1'b0;
                // the start decision uses the divisor held before this edge
                if (wr) begin
                    div_d = wr_div;
                end
                if (start_ok) begin
                    state_d  = RUN;
                    outclk_d = 1'b1;
                    tick_d   = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    div_d  = next_div;
                    pend_d = 1'b0;
                    if (en && next_ok) begin
                        outclk_d = 1'b1;
                        tick_d   = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        outclk_d = 1'b0;
                    end
                end else begin
                    cnt_d    = cnt_inc;
                    outclk_d = (cnt_inc < high_len);
                    // only the most recent write survives until the wrap
                    if (wr) begin
                        pdiv_d = wr_div;
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers so they are glitch-free
    always_comb begin
        outclk = outclk_q;
        tick   = tick_q;
        active = (state_q == RUN);
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: NUM_CH independent divided clocks from inclk.
//
// A single shared write port programs one channel's divisor per cycle; writes
// to a channel index of NUM_CH or above match no channel and are dropped.
//
// Ports:
//   inclk   - system clock
//   reset   - asynchronous active-low reset
//   wr_en   - divisor write strobe
//   wr_ch   - target channel of the write
//   wr_div  - new divisor (period in inclk cycles)
//   en      - per-channel run request
//   outclk  - per-channel divided clocks
//   tick    - per-channel pulse on each outclk rising edge
//   active  - per-channel running indication
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int WIDTH     = 32,
    parameter  int RESET_DIV = 2,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic              inclk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

        clock_divider_channel #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_channel (
            .inclk  (inclk),
            .reset  (reset),
            .wr     (wr_sel[i]),
            .wr_div (wr_div),
            .en     (en[i]),
            .outclk (outclk[i]),
            .tick   (tick[i]),
            .active (active[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed testbench for clock_divider_multi (NUM_CH=4, WIDTH=32, RESET_DIV=2).
// Inputs change and outputs are sampled on the falling edge of inclk.
// Expected waveforms are written as strings, one character per rising edge.
module tb_clock_divider_multi;

    logic        inclk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_div;
    logic [3:0]  en;
    logic [3:0]  outclk;
    logic [3:0]  tick;
    logic [3:0]  active;

    int testCount = 0;
    int failCount = 0;

    clock_divider_multi #(
        .NUM_CH    (4),
        .WIDTH     (32),
        .RESET_DIV (2)
    ) dut (
        .inclk  (inclk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .en     (en),
        .outclk (outclk),
        .tick   (tick),
        .active (active)
    );

    // 10-unit system clock
    always #5 inclk = ~inclk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present a divisor write; it is consumed by the next rising edge
    task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] div);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = div;
    endtask

    // Advance one rising edge, land on the falling edge, drop any write
    task automatic waitCycle();
        @(posedge inclk);
        @(negedge inclk);
        wr_en = 1'b0;
    endtask

    // Step one edge per pattern character and check outclk/tick of a channel
    task automatic checkSequence(input string tag, input int ch,
                                 input string outPat, input string tickPat);
        for (int i = 0; i < outPat.len(); i++) begin
            waitCycle();
            checkOutput($sformatf("%s.out%0d", tag, i), 32'(outclk[ch]),
                        (outPat[i] == "1") ? 32'd1 : 32'd0);
            checkOutput($sformatf("%s.tick%0d", tag, i), 32'(tick[ch]),
                        (tickPat[i] == "1") ? 32'd1 : 32'd0);
        end
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 2'd0;
        wr_div = 32'd0;
        en     = 4'h0;

        // Reset state
        #12;
        checkOutput("rst.outclk", 32'(outclk), 32'h0);
        checkOutput("rst.tick", 32'(tick), 32'h0);
        checkOutput("rst.active", 32'(active), 32'h0);
        @(negedge inclk);
        reset = 1'b1;
        @(negedge inclk);

        // ch0 with the reset divisor of 2: toggles every cycle
        en[0] = 1'b1;
        checkSequence("ch0", 0, "101010", "101010");
        checkOutput("ch0.active", 32'(active[0]), 32'd1);
        en[0] = 1'b0;
        checkSequence("ch0.stop", 0, "00", "00");
        checkOutput("ch0.idle", 32'(active[0]), 32'd0);

        // ch1 programmed to 5 while idle: 3 high, 2 low
        applyStimulus(2'd1, 32'd5);
        waitCycle();
        en[1] = 1'b1;
        checkSequence("ch1", 1, "1110011100", "1000010000");
        en[1] = 1'b0;
        checkSequence("ch1.stop", 1, "0", "0");
        checkOutput("ch1.idle", 32'(active[1]), 32'd0);

        // ch2 at 4, changed to 7 mid-period: current period completes first
        applyStimulus(2'd2, 32'd4);
        waitCycle();
        en[2] = 1'b1;
        checkSequence("ch2.d4", 2, "11", "10");
        applyStimulus(2'd2, 32'd7);
        checkSequence("ch2.d7", 2, "0011110001111000", "0010000001000000");

        // Writes landing on the wrap edge apply to the very next period
        applyStimulus(2'd2, 32'd4);
        checkSequence("ch2.wrap4", 2, "1100", "1000");
        applyStimulus(2'd2, 32'd6);
        checkSequence("ch2.wrap6", 2, "11100011", "10000010");

        // Two writes in one period: only the later one (3) is used
        applyStimulus(2'd2, 32'd9);
        checkSequence("ch2.w9", 2, "1", "0");
        applyStimulus(2'd2, 32'd3);
        checkSequence("ch2.w3", 2, "0001101", "0001001");
        en[2] = 1'b0;
        checkSequence("ch2.stop", 2, "100", "000");
        checkOutput("ch2.idle", 32'(active[2]), 32'd0);

        // ch3 at 10, en dropped at cnt=2: period runs to completion
        applyStimulus(2'd3, 32'd10);
        waitCycle();
        en[3] = 1'b1;
        checkSequence("ch3.run", 3, "111", "100");
        en[3] = 1'b0;
        checkSequence("ch3.drain", 3, "1100000", "0000000");
        checkOutput("ch3.stillactive", 32'(active[3]), 32'd1);
        checkSequence("ch3.stop", 3, "000", "000");
        checkOutput("ch3.idle", 32'(active[3]), 32'd0);

        // Divisor 1 is illegal: channel refuses to start
        applyStimulus(2'd3, 32'd1);
        waitCycle();
        en[3] = 1'b1;
        checkSequence("ch3.d1", 3, "000", "000");
        checkOutput("ch3.d1.active", 32'(active[3]), 32'd0);

        // Reset mid-period with all channels requested
        en = 4'hF;
        waitCycle();
        checkOutput("pre.outclk", 32'(outclk), 32'h7);
        checkOutput("pre.active", 32'(active), 32'h7);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid.outclk", 32'(outclk), 32'h0);
        checkOutput("mid.tick", 32'(tick), 32'h0);
        checkOutput("mid.active", 32'(active), 32'h0);
        waitCycle();
        checkOutput("hold.outclk", 32'(outclk), 32'h0);
        reset = 1'b1;

        // After release every channel restarts with divisor 2
        waitCycle();
        checkOutput("post0.outclk", 32'(outclk), 32'hF);
        checkOutput("post0.tick", 32'(tick), 32'hF);
        checkOutput("post0.active", 32'(active), 32'hF);
        waitCycle();
        checkOutput("post1.outclk", 32'(outclk), 32'h0);
        checkOutput("post1.tick", 32'(tick), 32'h0);
        waitCycle();
        checkOutput("post2.outclk", 32'(outclk), 32'hF);
        checkOutput("post2.tick", 32'(tick), 32'hF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
